// File: rtl/rd_ptr_empty.sv
`default_nettype none
// ============================================================================
// Module      : rd_ptr_empty
// Description : Read-side pointer and empty-flag controller for an async FIFO.
//               Owns the binary/Gray read pointer, synchronizes the write
//               Gray pointer into rd_clk, and derives empty, almost_empty and
//               occupancy. Optional macro RD_UNDERFLOW_EN enables the sticky
//               underflow flag; otherwise underflow is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_ptr_empty #(
    parameter int SIZE      = 4,
    parameter int AE_THRESH = 2
) (
    input  logic            rd_clk,
    input  logic            rst_n,
    input  logic            read_en,
    input  logic [SIZE:0]   wr_ptr_gray_in,
    output logic [SIZE-1:0] rd_addr,
    output logic [SIZE:0]   rd_ptr_gray,
    output logic            rd_fire,
    output logic            empty,
    output logic            almost_empty,
    output logic [SIZE:0]   rd_count,
    output logic            underflow
);

    localparam logic [SIZE:0] c_AE_THRESH = AE_THRESH[SIZE:0];

    logic [SIZE:0] r_rd_ptr_bin;
    logic [SIZE:0] r_rd_ptr_gray;
    logic [SIZE:0] r_sync1;
    logic [SIZE:0] r_sync2;
    logic          r_empty;
    logic          r_almost_empty;
    logic [SIZE:0] r_rd_count;

    logic [SIZE:0] w_wq_bin;
    logic [SIZE:0] w_rd_bin_next;
    logic [SIZE:0] w_rd_gray_next;
    logic [SIZE:0] w_count_next;
    logic          w_rd_fire;

    // Two-flop synchronizer for the write Gray pointer; nothing between stages.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= wr_ptr_gray_in;
            r_sync2 <= r_sync1;
        end
    end

    // Gray-to-binary of the synchronized write pointer, accept rule and next pointer.
    always_comb begin
        w_wq_bin = '0;
        for (int i = 0; i <= SIZE; i++) begin
            w_wq_bin[i] = ^(r_sync2 >> i);
        end
        w_rd_fire      = read_en & ~r_empty;
        w_rd_bin_next  = r_rd_ptr_bin + {{SIZE{1'b0}}, w_rd_fire};
        w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);
        w_count_next   = w_wq_bin - w_rd_bin_next;
    end

    // Read pointer registers advance only on an accepted read.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr_bin  <= '0;
            r_rd_ptr_gray <= '0;
        end else begin
            r_rd_ptr_bin  <= w_rd_bin_next;
            r_rd_ptr_gray <= w_rd_gray_next;
        end
    end

    // Status flags and occupancy, computed from the post-read pointer so the
    // last read sets empty on the same edge the pointer moves.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_count     <= '0;
        end else begin
            r_empty        <= (w_rd_gray_next == r_sync2);
            r_almost_empty <= (w_count_next <= c_AE_THRESH);
            r_rd_count     <= w_count_next;
        end
    end

`ifdef RD_UNDERFLOW_EN
    logic r_underflow;

    // Sticky record of any read attempted while empty; only reset clears it.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (read_en && r_empty) begin
            r_underflow <= 1'b1;
        end
    end

    assign underflow = r_underflow;
`else
    assign underflow = 1'b0;
`endif

    assign rd_addr      = r_rd_ptr_bin[SIZE-1:0];
    assign rd_ptr_gray  = r_rd_ptr_gray;
    assign rd_fire      = w_rd_fire;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_count     = r_rd_count;

endmodule
`default_nettype wire

// File: tb/tb_rd_ptr_empty.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_ptr_empty
// Description : Directed self-checking bench for rd_ptr_empty (SIZE=4,
//               AE_THRESH=2). Honours RD_UNDERFLOW_EN for the underflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_ptr_empty;

`ifdef RD_UNDERFLOW_EN
    localparam logic c_UF = 1'b1;
`else
    localparam logic c_UF = 1'b0;
`endif

    logic       rd_clk;
    logic       rst_n;
    logic       read_en;
    logic [4:0] wr_ptr_gray_in;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr_gray;
    logic       rd_fire;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_count;
    logic       underflow;

    int n_vec;
    int n_err;

    rd_ptr_empty #(
        .SIZE      (4),
        .AE_THRESH (2)
    ) dut (
        .rd_clk         (rd_clk),
        .rst_n          (rst_n),
        .read_en        (read_en),
        .wr_ptr_gray_in (wr_ptr_gray_in),
        .rd_addr        (rd_addr),
        .rd_ptr_gray    (rd_ptr_gray),
        .rd_fire        (rd_fire),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .rd_count       (rd_count),
        .underflow      (underflow)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".ae"},    32'(almost_empty), 32'd1);
        chk({tag, ".addr"},  32'(rd_addr), 32'd0);
        chk({tag, ".gray"},  32'(rd_ptr_gray), 32'd0);
        chk({tag, ".count"}, 32'(rd_count), 32'd0);
        chk({tag, ".uf"},    32'(underflow), 32'd0);
        chk({tag, ".fire"},  32'(rd_fire), 32'd0);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        read_en        = 1'b0;
        wr_ptr_gray_in = 5'b00000;

        // Reset held, then released
        tick();
        tick();
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("rst_rel");

        // Fill visibility: bin 3 becomes visible after the third edge
        wr_ptr_gray_in = 5'b00010;
        tick();                                     // edge N
        chk("fill.N.empty", 32'(empty), 32'd1);
        chk("fill.N.count", 32'(rd_count), 32'd0);
        tick();                                     // edge N+1
        chk("fill.N1.empty", 32'(empty), 32'd1);
        chk("fill.N1.ae",    32'(almost_empty), 32'd1);
        tick();                                     // edge N+2
        chk("fill.N2.empty", 32'(empty), 32'd0);
        chk("fill.N2.count", 32'(rd_count), 32'd3);
        chk("fill.N2.ae",    32'(almost_empty), 32'd0);

        // Drain 3 entries with read_en held for 4 cycles
        read_en = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            automatic int ptr = (k < 3) ? k + 1 : 3;
            chk($sformatf("drain%0d.fire", k), 32'(rd_fire), (k < 3) ? 32'd1 : 32'd0);
            chk($sformatf("drain%0d.addr_pre", k), 32'(rd_addr), (k < 3) ? 32'(k) : 32'd3);
            tick();
            chk($sformatf("drain%0d.addr", k),  32'(rd_addr), 32'(ptr));
            chk($sformatf("drain%0d.count", k), 32'(rd_count), 32'(3 - ptr));
            chk($sformatf("drain%0d.empty", k), 32'(empty), (ptr == 3) ? 32'd1 : 32'd0);
            chk($sformatf("drain%0d.ae", k),    32'(almost_empty), 32'd1);
        end
        read_en = 1'b0;
        chk("drain.gray", 32'(rd_ptr_gray), 32'b00010);
        chk("drain.uf",   32'(underflow), 32'(c_UF));

        // Wrap to bin 16
        wr_ptr_gray_in = 5'b11000;
        tick(); tick(); tick();
        chk("wrap16.count", 32'(rd_count), 32'd13);
        chk("wrap16.empty", 32'(empty), 32'd0);
        read_en = 1'b1;
        #1;
        for (int j = 3; j < 16; j++) begin
            chk($sformatf("wrap16.fire%0d", j), 32'(rd_fire), 32'd1);
            chk($sformatf("wrap16.addr%0d", j), 32'(rd_addr), 32'(j));
            tick();
        end
        read_en = 1'b0;
        chk("wrap16.addr_end", 32'(rd_addr), 32'd0);
        chk("wrap16.gray",     32'(rd_ptr_gray), 32'b11000);
        chk("wrap16.empty_end", 32'(empty), 32'd1);
        chk("wrap16.uf_kept",  32'(underflow), 32'(c_UF));

        // Wrap to bin 32 (Gray 00000): full FIFO then drain
        wr_ptr_gray_in = 5'b00000;
        tick(); tick(); tick();
        chk("wrap32.count", 32'(rd_count), 32'd16);
        chk("wrap32.empty", 32'(empty), 32'd0);
        chk("wrap32.ae",    32'(almost_empty), 32'd0);
        read_en = 1'b1;
        #1;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("wrap32.addr%0d", j), 32'(rd_addr), 32'(j));
            tick();
        end
        read_en = 1'b0;
        chk("wrap32.gray",  32'(rd_ptr_gray), 32'b00000);
        chk("wrap32.addr",  32'(rd_addr), 32'd0);
        chk("wrap32.empty", 32'(empty), 32'd1);
        chk("wrap32.count_end", 32'(rd_count), 32'd0);

        // Reset mid-operation at count 5 (bin 5 = Gray 00111)
        wr_ptr_gray_in = 5'b00111;
        tick(); tick(); tick();
        chk("mid.count5", 32'(rd_count), 32'd5);
        read_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        read_en = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();                                     // sync1 captures
        chk("post.E1.empty", 32'(empty), 32'd1);
        tick();                                     // sync2 captures
        chk("post.E2.empty", 32'(empty), 32'd1);
        chk("post.E2.count", 32'(rd_count), 32'd0);
        tick();
        chk("post.E3.empty", 32'(empty), 32'd0);
        chk("post.E3.count", 32'(rd_count), 32'd5);

        // Simultaneous reads and write-pointer advance to bin 7 (Gray 00100)
        read_en        = 1'b1;
        wr_ptr_gray_in = 5'b00100;
        #1;
        chk("sim.fire", 32'(rd_fire), 32'd1);
        tick();
        chk("sim.A.count", 32'(rd_count), 32'd4);
        chk("sim.A.ae",    32'(almost_empty), 32'd0);
        tick();
        chk("sim.B.count", 32'(rd_count), 32'd3);
        tick();
        chk("sim.C.count", 32'(rd_count), 32'd4);
        chk("sim.C.addr",  32'(rd_addr), 32'd3);
        read_en = 1'b0;
        tick();
        chk("sim.D.count", 32'(rd_count), 32'd4);
        chk("sim.D.addr",  32'(rd_addr), 32'd3);
        chk("sim.D.empty", 32'(empty), 32'd0);
        chk("sim.D.uf",    32'(underflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rd_ptr_empty.md
Name: rd_ptr_empty

Overview:
- Read-side pointer and empty-flag controller for the asynchronous FIFO. Counterpart of the write-pointer block.
- Lives entirely in the read clock domain and owns the binary read pointer and its Gray-coded copy.
- Synchronizes the write-domain Gray pointer into the read domain and derives empty, almost-empty and occupancy.
- Drives the RAM read address and exports the registered Gray read pointer for the write-side full logic.

Parameters:
- SIZE, 4, RAM address width; FIFO depth = 2^SIZE; pointers are SIZE+1 bits wide (MSB is the wrap bit).
- AE_THRESH, 2, almost_empty asserts when occupancy <= AE_THRESH; legal range 0..2^SIZE-1.

Ports:
- rd_clk  input  1  read-domain clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read_en  input  1  read request from the consumer.
- wr_ptr_gray_in  input  SIZE+1  Gray write pointer from the write domain; asynchronous to rd_clk.
- rd_addr  output  SIZE  RAM read address, equal to rd_ptr_bin[SIZE-1:0].
- rd_ptr_gray  output  SIZE+1  registered Gray read pointer, sent to the write domain.
- rd_fire  output  1  combinational; high when a read is accepted this cycle.
- empty  output  1  registered empty flag.
- almost_empty  output  1  registered almost-empty flag.
- rd_count  output  SIZE+1  registered occupancy as seen by the read domain.
- underflow  output  1  sticky read-while-empty flag; used only with the optional feature.

Behaviour:
- Reset values: pointer binary and Gray = 0, both sync stages = 0, rd_addr = 0, rd_ptr_gray = 0, empty = 1, almost_empty = 1, rd_count = 0, underflow = 0.
- Reset acts immediately on rst_n low, including mid-operation. Any in-flight state is discarded and every register returns to its reset value.
- Synchronizer: two flops, sync1 then sync2, clocked by rd_clk and capturing wr_ptr_gray_in. No logic is allowed between the two stages.
- Gray-to-binary conversion of sync2 produces wq_bin: bit i = XOR of sync2 bits SIZE down to i.
- Accept rule: rd_fire = read_en & ~empty.
- rd_bin_next = rd_ptr_bin + rd_fire, modulo 2^(SIZE+1). The pointer wraps from 2^(SIZE+1)-1 to 0 with no special case.
- rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1). Both pointer registers update every cycle from these next values.
- Empty: next-state value is (rd_gray_next == sync2), registered.
  - A read that consumes the last visible entry sets empty on the same edge the pointer advances.
- Count: next-state rd_count = wq_bin - rd_bin_next, modulo 2^(SIZE+1), registered. The maximum legal value is 2^SIZE.
- almost_empty next-state value is (count_next <= AE_THRESH), registered. It is always 1 whenever empty is 1.
- Write-pointer latency: a change on wr_ptr_gray_in that is stable before rd_clk edge N reaches sync1 at N and sync2 at N+1. empty, rd_count and almost_empty reflect it after edge N+2.
- Simultaneous read and write-pointer advance:
  - The read uses the current empty value.
  - The new write pointer is folded in per the latency above.
  - The count stays exact, with no double counting.
- Read while empty: the request is ignored. Pointers do not move, rd_fire = 0, and no RAM address change occurs.
- Flags are conservative (pessimistic). Synchronizer lag can only delay the deassertion of empty; it never asserts empty falsely late.

Optional Feature:
- Macro: RD_UNDERFLOW_EN.
- Defined: underflow sets on any rising edge where read_en = 1 and empty = 1, and stays set until rst_n is asserted.
- Not defined: the underflow port remains present, is tied to 0, and no flop is inferred.

Test Plan:
- Reset check (SIZE=4): hold rst_n=0, then release → empty=1, almost_empty=1, rd_addr=0, rd_ptr_gray=5'b00000, rd_count=0, underflow=0.
- Fill visibility: drive wr_ptr_gray_in=5'b00010 (bin 3) before edge N → empty=0, rd_count=3, almost_empty=0 after edge N+2; both remain 1 through edge N+1.
- Drain: from count 3, hold read_en=1 for 4 cycles:
  - rd_addr steps 0,1,2; rd_fire high for exactly 3 cycles.
  - empty=1 and rd_count=0 after the 3rd accepted read.
  - rd_ptr_gray=5'b00010.
  - almost_empty=1 once rd_count is 2.
- Underflow (RD_UNDERFLOW_EN defined): read_en=1 while empty → rd_ptr_gray unchanged, underflow=1 and it stays 1 after later valid reads. Without the macro, underflow stays 0.
- Wrap: drive wr_ptr_gray_in=5'b11000 (bin 16) and read 16 entries:
  - rd_addr runs 0..15, then returns to 0.
  - rd_ptr_gray=5'b11000, empty=1.
  - Repeat to bin 32, i.e. wr_ptr_gray_in=5'b00000 → rd_ptr_gray wraps to 5'b00000.
- Reset mid-drain: assert rst_n=0 for 1 cycle at rd_count=5 → all outputs return to reset values immediately. Afterwards empty stays 1 until a new write pointer propagates through the synchronizer.
